// File: rtl/dualportram_copy_pkg.sv
// dualportram_copy_pkg
//   Shared types and constants for the dual-port RAM copy/fill sequencer.
//   state_t      : sequencer states
//   MODE_COPY    : copy source range to destination range
//   MODE_FILL    : fill destination range with a constant pattern
//   range_bad()  : 33-bit overflow-safe check of base+len against the RAM size
package dualportram_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // The extra carry bit means a base near 2^32 cannot wrap and slip under the limit.
  function automatic logic range_bad(input logic [31:0] base,
                                     input logic [31:0] len,
                                     input logic [31:0] limit);
    logic [32:0] w_end;
    w_end = {1'b0, base} + {1'b0, len};
    return w_end > {1'b0, limit};
  endfunction

endpackage

// File: rtl/dualportram_copy_csum.sv
// dualportram_copy_csum
//   Running modulo-2^WIDTH sum of every word written to the destination port.
//   Only built when DUALPORTRAM_COPY_CSUM_EN is defined.
//   Ports:
//     clk, reset    : clock, async active-high reset
//     i_clr         : clear the sum (accepted start)
//     i_add_en      : add i_add_val this cycle (port B write strobe)
//     i_add_val     : word being written
//     o_csum        : accumulated sum
module dualportram_copy_csum
  import dualportram_copy_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_add_en,
  input  logic [WIDTH-1:0] i_add_val,
  output logic [WIDTH-1:0] o_csum
);

  logic [WIDTH-1:0] r_csum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum <= '0;
    end else if (i_clr) begin
      r_csum <= '0;
    end else if (i_add_en) begin
      r_csum <= r_csum + i_add_val;
    end
  end

  assign o_csum = r_csum;

endmodule

// File: rtl/dualportram_copy_engine.sv
// dualportram_copy_engine
//   Sequencer that copies or fills a word range of a dual-port RAM, one word per
//   cycle. Port A reads the source, port B writes the destination.
//   Optional feature macro: DUALPORTRAM_COPY_CSUM_EN adds the csum output.
//   Ports:
//     clk, reset                 : clock, async active-high reset
//     start/mode/src/dst/len/pattern/abort : command interface (sampled in IDLE)
//     busy/done/err              : status (done/err are 1-cycle pulses)
//     ram_length                 : RAM size in words
//     we/oe/address/din/dout     : RAM port A (read only; we and din tied 0)
//     we_b/oe_b/address_b/din_b  : RAM port B (write only; oe_b tied 0)
//     csum (macro only)          : sum of all words written since last start
//
//   state | meaning
//   IDLE  | waiting for start; done pulse emitted here after completion
//   RUN   | one word per cycle (COPY: read k, write k-1; FILL: write k)
//   FLUSH | COPY: last write from read data; FILL: empty slot for equal timing
//   ERR   | range error, err high for this single cycle
module dualportram_copy_engine
  import dualportram_copy_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [31:0]      len,
  input  logic [WIDTH-1:0] pattern,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [31:0]      ram_length,
  output logic             we,
  output logic             oe,
  output logic [31:0]      address,
  output logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] dout,
  output logic             we_b,
  output logic             oe_b,
  output logic [31:0]      address_b,
  output logic [WIDTH-1:0] din_b
`ifdef DUALPORTRAM_COPY_CSUM_EN
  ,
  output logic [WIDTH-1:0] csum
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_mode;
  logic [WIDTH-1:0] r_pattern;
  logic [31:0]      r_rd_addr;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_remain;
  logic             r_wr_vld;
  logic             r_done;

  logic             w_accept;
  logic             w_len_zero;
  logic             w_range_err;
  logic             w_last;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_len_zero  = (len == 32'd0);
  assign w_range_err = ((mode == MODE_COPY) && range_bad(src, len, ram_length)) ||
                       range_bad(dst, len, ram_length);
  assign w_last      = (r_remain == 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Zero length wins over the range check: nothing is accessed, so nothing can be out of range.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_len_zero)       w_state_nxt = IDLE;
          else if (w_range_err) w_state_nxt = ERR;
          else                  w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort)       w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = FLUSH;
      end
      FLUSH:   w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: read address, write address (lags one word in COPY) and down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode    <= MODE_COPY;
      r_pattern <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_remain  <= '0;
      r_wr_vld  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode    <= mode;
            r_pattern <= pattern;
            r_rd_addr <= src;
            r_wr_addr <= dst;
            r_remain  <= len;
            r_wr_vld  <= 1'b0;
            r_done    <= w_len_zero;
          end
        end
        RUN: begin
          if (!abort) begin
            r_rd_addr <= r_rd_addr + 32'd1;
            r_remain  <= r_remain - 32'd1;
            if (r_mode == MODE_COPY) r_wr_vld <= 1'b1;
            if ((r_mode == MODE_FILL) || r_wr_vld) r_wr_addr <= r_wr_addr + 32'd1;
          end
        end
        FLUSH: begin
          if (!abort) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state == RUN) || (r_state == FLUSH);
    done      = r_done;
    err       = (r_state == ERR);
    we        = 1'b0;
    din       = '0;
    oe_b      = 1'b0;
    oe        = 1'b0;
    address   = '0;
    we_b      = 1'b0;
    address_b = '0;
    din_b     = '0;
    case (r_state)
      RUN: begin
        if (r_mode == MODE_COPY) begin
          oe      = 1'b1;
          address = r_rd_addr;
          if (r_wr_vld) begin
            we_b      = 1'b1;
            address_b = r_wr_addr;
            din_b     = dout;
          end
        end else begin
          we_b      = 1'b1;
          address_b = r_wr_addr;
          din_b     = r_pattern;
        end
      end
      FLUSH: begin
        if (r_mode == MODE_COPY) begin
          we_b      = 1'b1;
          address_b = r_wr_addr;
          din_b     = dout;
        end
      end
      default: ;
    endcase
  end

`ifdef DUALPORTRAM_COPY_CSUM_EN
  dualportram_copy_csum #(.WIDTH(WIDTH)) u_csum (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_accept),
    .i_add_en  (we_b),
    .i_add_val (din_b),
    .o_csum    (csum)
  );
`else
  logic w_unused;
  assign w_unused = w_accept;
`endif

endmodule
